// File: rtl/xsquash_scheduler.sv
// Round-robin scheduler sharing one external X-squasher among NREQ requesters.
// Each accepted word takes three cycles: accept, issue to the squasher, then return the response.
module xsquash_scheduler #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic                  squash_en,
   input  logic [NREQ-1:0]       req_mask,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [IDW-1:0]        resp_id,
   output logic [WIDTH-1:0]      resp_data,
   output logic                  sq_valid,
   output logic [WIDTH-1:0]      sq_inp,
   input  logic [WIDTH-1:0]      sq_outp,
   output logic                  busy,
   output logic [15:0]           xact_count
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t           state;
   logic [IDW-1:0]   last_grant;
   logic [IDW-1:0]   grant_idx;
   logic             grant_any;
   logic [NREQ-1:0]  elig;
   logic [WIDTH-1:0] grant_data;
   logic [15:0]      xact_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign elig = req_valid & ~req_mask;

   // Walk downward so the candidate nearest last_grant+1 is the one that sticks.
   always_comb begin
      int unsigned    pos;
      logic [IDW-1:0] idx_w;
      grant_any = 1'b0;
      grant_idx = '0;
      pos       = 0;
      idx_w     = '0;
      for (int k = NREQ; k >= 1; k--) begin
         pos   = (int'(last_grant) + k) % NREQ;
         idx_w = IDW'(pos);
         if (elig[idx_w]) begin
            grant_any = 1'b1;
            grant_idx = idx_w;
         end
      end
   end

   always_comb begin
      grant_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (IDW'(k) == grant_idx) grant_data = req_data[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == IDLE && reset_n && grant_any) req_ready[grant_idx] = 1'b1;
   end

   assign busy       = (state != IDLE);
   assign xact_count = xact_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         xact_q     <= '0;
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_data  <= '0;
         sq_valid   <= 1'b0;
         sq_inp     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_any) begin
                  sq_inp   <= grant_data;
                  sq_valid <= squash_en;
                  resp_id  <= grant_idx;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               resp_data  <= sq_outp;
               resp_valid <= 1'b1;
               sq_valid   <= 1'b0;
               sq_inp     <= '0;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  last_grant <= resp_id;
                  xact_q     <= sat_inc(xact_q);
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xsquash_scheduler.sv
// Directed bench for xsquash_scheduler with a behavioural squasher model on the sq_* port.
module tb_xsquash_scheduler;

   logic         clock = 1'b0;
   logic         reset_n;
   logic [3:0]   req_valid;
   logic [3:0]   req_ready;
   logic [127:0] req_data;
   logic         squash_en;
   logic [3:0]   req_mask;
   logic         resp_valid;
   logic         resp_ready;
   logic [1:0]   resp_id;
   logic [31:0]  resp_data;
   logic         sq_valid;
   logic [31:0]  sq_inp;
   logic [31:0]  sq_outp;
   logic         busy;
   logic [15:0]  xact_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] xval;

   xsquash_scheduler #(.WIDTH(32), .NREQ(4)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .squash_en(squash_en), .req_mask(req_mask),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_data(resp_data), .sq_valid(sq_valid), .sq_inp(sq_inp), .sq_outp(sq_outp),
      .busy(busy), .xact_count(xact_count)
   );

   always #5 clock = ~clock;

   // Squasher stand-in: unknown bits resolve to an alternating 0/1 pattern when enabled.
   always_comb begin
      sq_outp = sq_inp;
      if (sq_valid) begin
         for (int i = 0; i < 32; i++) begin
            if ($isunknown(sq_inp[i])) sq_outp[i] = (i % 2 == 1);
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] lane_val(input int k);
      return 32'hA000_0000 + 32'(k) * 32'h0101_0101;
   endfunction

   // Entered at a negedge in IDLE with inputs already set; leaves at the negedge back in IDLE.
   task automatic run_xact(input string tag, input int exp_id, input logic [31:0] exp_data,
                           input int hold);
      #1 chk({tag, ".req_ready"}, 64'(req_ready), 64'(4'b0001 << exp_id));
      @(negedge clock);
      chk({tag, ".sq_valid"}, 64'(sq_valid), 64'(squash_en));
      chk({tag, ".sq_inp"}, 64'(sq_inp), 64'(exp_data));
      chk({tag, ".ready_issue"}, 64'(req_ready), 64'd0);
      @(negedge clock);
      chk({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
      chk({tag, ".resp_id"}, 64'(resp_id), 64'(exp_id));
      chk({tag, ".resp_data"}, 64'(resp_data), 64'(exp_data));
      if (hold > 0) begin
         resp_ready = 1'b0;
         repeat (hold) begin
            @(negedge clock);
            chk({tag, ".hold_valid"}, 64'(resp_valid), 64'd1);
            chk({tag, ".hold_id"}, 64'(resp_id), 64'(exp_id));
            chk({tag, ".hold_data"}, 64'(resp_data), 64'(exp_data));
            chk({tag, ".hold_ready"}, 64'(req_ready), 64'd0);
            chk({tag, ".hold_busy"}, 64'(busy), 64'd1);
         end
         resp_ready = 1'b1;
      end
      @(negedge clock);
      chk({tag, ".done_valid"}, 64'(resp_valid), 64'd0);
      chk({tag, ".done_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      xval       = 32'h0000_00xx;
      reset_n    = 1'b0;
      req_valid  = 4'b0001;
      req_mask   = 4'b0000;
      squash_en  = 1'b1;
      resp_ready = 1'b1;
      req_data   = '0;
      for (int k = 0; k < 4; k++) req_data[k*32 +: 32] = lane_val(k);
      repeat (2) @(negedge clock);

      chk("rst.resp_valid", 64'(resp_valid), 64'd0);
      chk("rst.xact", 64'(xact_count), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.sq_valid", 64'(sq_valid), 64'd0);
      chk("rst.resp_id", 64'(resp_id), 64'd0);
      chk("rst.resp_data", 64'(resp_data), 64'd0);
      chk("rst.req_ready", 64'(req_ready), 64'd0);

      // Single request through the squasher.
      reset_n = 1'b1;
      req_data[0 +: 32] = 32'hDEAD_BEEF;
      #1 chk("single.req_ready", 64'(req_ready), 64'h1);
      @(negedge clock);
      req_valid = 4'b0000;
      chk("single.sq_valid", 64'(sq_valid), 64'd1);
      chk("single.sq_inp", 64'(sq_inp), 64'hDEAD_BEEF);
      chk("single.busy", 64'(busy), 64'd1);
      @(negedge clock);
      chk("single.resp_valid", 64'(resp_valid), 64'd1);
      chk("single.resp_id", 64'(resp_id), 64'd0);
      chk("single.resp_data", 64'(resp_data), 64'hDEAD_BEEF);
      @(negedge clock);
      chk("single.xact", 64'(xact_count), 64'd1);
      chk("single.idle", 64'(resp_valid), 64'd0);
      req_data[0 +: 32] = lane_val(0);

      // Unknown low byte with squashing enabled.
      req_data[64 +: 32] = xval;
      req_valid = 4'b0100;
      #1 chk("xsq.req_ready", 64'(req_ready), 64'h4);
      @(negedge clock);
      req_valid = 4'b0000;
      chk("xsq.sq_valid", 64'(sq_valid), 64'd1);
      @(negedge clock);
      chk("xsq.resp_id", 64'(resp_id), 64'd2);
      chk("xsq.known", 64'($isunknown(resp_data)), 64'd0);
      chk("xsq.upper", 64'(resp_data[31:8]), 64'd0);
      @(negedge clock);

      // Same word with squashing disabled passes straight through.
      squash_en = 1'b0;
      req_valid = 4'b0100;
      #1 chk("xraw.req_ready", 64'(req_ready), 64'h4);
      @(negedge clock);
      req_valid = 4'b0000;
      chk("xraw.sq_valid", 64'(sq_valid), 64'd0);
      chk("xraw.sq_inp", 64'(sq_inp), 64'(xval));
      @(negedge clock);
      chk("xraw.resp_data", 64'(resp_data), 64'(xval));
      @(negedge clock);
      chk("xraw.xact", 64'(xact_count), 64'd3);
      squash_en = 1'b1;
      req_data[64 +: 32] = lane_val(2);

      // Reset while requester 2 waits in RESP.
      req_valid  = 4'b0100;
      resp_ready = 1'b0;
      #1 chk("rmid.req_ready", 64'(req_ready), 64'h4);
      @(negedge clock);
      req_valid = 4'b1111;
      @(negedge clock);
      chk("rmid.resp_valid", 64'(resp_valid), 64'd1);
      chk("rmid.resp_id", 64'(resp_id), 64'd2);
      reset_n = 1'b0;
      @(negedge clock);
      chk("rmid.after_valid", 64'(resp_valid), 64'd0);
      chk("rmid.after_xact", 64'(xact_count), 64'd0);
      chk("rmid.after_busy", 64'(busy), 64'd0);
      chk("rmid.ready_in_rst", 64'(req_ready), 64'd0);
      reset_n    = 1'b1;
      resp_ready = 1'b1;

      // Round robin with everyone requesting, starting from requester 0.
      for (int i = 0; i < 8; i++) run_xact("rr", i % 4, lane_val(i % 4), 0);
      chk("rr.xact", 64'(xact_count), 64'd8);

      // Masked lanes 0 and 2; third grant stalls under backpressure.
      req_mask = 4'b0101;
      run_xact("mask0", 1, lane_val(1), 0);
      run_xact("mask1", 3, lane_val(3), 0);
      run_xact("mask2", 1, lane_val(1), 10);
      run_xact("mask3", 3, lane_val(3), 0);
      chk("mask.xact", 64'(xact_count), 64'd12);

      // Everyone masked: nothing is granted.
      req_mask = 4'b1111;
      #1 chk("allmask.req_ready", 64'(req_ready), 64'd0);
      @(negedge clock);
      chk("allmask.busy", 64'(busy), 64'd0);

      // Saturating completion counter.
      req_mask = 4'b0000;
      force dut.xact_q = 16'hFFFE;
      #1 release dut.xact_q;
      chk("sat.preset", 64'(xact_count), 64'hFFFE);
      for (int i = 0; i < 3; i++) begin
         run_xact("sat", i, lane_val(i), 0);
         chk("sat.xact", 64'(xact_count), 64'hFFFF);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
